// File: rtl/mx_sum_sb_pkg.sv
// Shared types and helpers for the MX block-sum scoreboard: FIFO entry payload,
// default geometry and FP32 classification / ulp distance used by the tolerant compare.
package mx_sum_sb_pkg;

    localparam int unsigned SB_DATA_W = 32;
    localparam int unsigned SB_EXP_W  = 8;
    localparam int unsigned SB_MAG_W  = SB_DATA_W - 1;
    localparam int unsigned SB_MAN_W  = SB_MAG_W - SB_EXP_W;
    localparam int unsigned SB_DEPTH  = 8;
    localparam int unsigned SB_PTR_W  = $clog2(SB_DEPTH);
    localparam int unsigned SB_CNT_W  = 16;

    typedef struct packed {
        logic [SB_DATA_W-1:0] data;
        logic                 overflow;
        logic                 unused;
    } sb_entry_t;

    function automatic logic is_zero(input logic [SB_DATA_W-1:0] x);
        return x[SB_MAG_W-1:0] == '0;
    endfunction

    function automatic logic is_nan(input logic [SB_DATA_W-1:0] x);
        return (&x[SB_MAG_W-1:SB_MAN_W]) && (x[SB_MAN_W-1:0] != '0);
    endfunction

    function automatic logic is_inf(input logic [SB_DATA_W-1:0] x);
        return (&x[SB_MAG_W-1:SB_MAN_W]) && (x[SB_MAN_W-1:0] == '0);
    endfunction

    // Magnitude-field distance; for same-sign finite floats this is the ulp count.
    function automatic logic [SB_MAG_W-1:0] ulp_dist(input logic [SB_DATA_W-1:0] a,
                                                     input logic [SB_DATA_W-1:0] b);
        logic [SB_MAG_W-1:0] ma;
        logic [SB_MAG_W-1:0] mb;
        ma = a[SB_MAG_W-1:0];
        mb = b[SB_MAG_W-1:0];
        return (ma >= mb) ? (ma - mb) : (mb - ma);
    endfunction

endpackage

// File: rtl/mx_sum_scoreboard_if.sv
// Reference/DUT result streams and status of the block-sum scoreboard.
// master = environment side, slave = scoreboard side.
interface mx_sum_scoreboard_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic                  i_clear;
    logic                  i_ref_valid;
    logic                  o_ref_ready;
    logic [DATA_WIDTH-1:0] i_ref_data;
    logic                  i_ref_overflow;
    logic                  i_ref_unused;
    logic                  i_dut_valid;
    logic [DATA_WIDTH-1:0] i_dut_data;
    logic                  i_dut_overflow;
    logic [CNT_W-1:0]      o_txn_count;
    logic [CNT_W-1:0]      o_err_count;
    logic                  o_err_valid;
    logic [CNT_W-1:0]      o_err_id;
    logic [DATA_WIDTH-1:0] o_err_ref;
    logic [DATA_WIDTH-1:0] o_err_dut;
    logic                  o_orphan;
    logic [LVL_W-1:0]      o_fifo_level;

    modport master (
        output i_clear, i_ref_valid, i_ref_data, i_ref_overflow, i_ref_unused,
        output i_dut_valid, i_dut_data, i_dut_overflow,
        input  o_ref_ready, o_txn_count, o_err_count, o_err_valid, o_err_id,
        input  o_err_ref, o_err_dut, o_orphan, o_fifo_level
    );

    modport slave (
        input  i_clear, i_ref_valid, i_ref_data, i_ref_overflow, i_ref_unused,
        input  i_dut_valid, i_dut_data, i_dut_overflow,
        output o_ref_ready, o_txn_count, o_err_count, o_err_valid, o_err_id,
        output o_err_ref, o_err_dut, o_orphan, o_fifo_level
    );

endinterface

// File: rtl/mx_sum_sb_fifo.sv
// Synchronous FIFO of scoreboard reference entries with registered full/empty/level.
// Push while full and pop while empty are ignored; pointers wrap modulo DEPTH.
module mx_sum_sb_fifo
    import mx_sum_sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  sb_entry_t                wr_entry,
    output sb_entry_t                head_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    sb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [LVL_W-1:0] level_nxt;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // Pointers and occupancy flags; flags are registered from the next level.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == LVL_W'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

endmodule

// File: rtl/mx_sum_scoreboard.sv
// In-order scoreboard for MX block-sum results: FIFO-buffered references, one registered compare
// stage, saturating counters and last-error capture. Optional ulp-tolerant compare: MX_SUM_SB_ULP_TOL_EN.
module mx_sum_scoreboard
    import mx_sum_sb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SB_DATA_W,
    parameter int unsigned DEPTH      = SB_DEPTH,
    parameter int unsigned CNT_W      = SB_CNT_W,
    parameter int unsigned ULP_TOL    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mx_sum_scoreboard_if.slave sb
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    if (DATA_WIDTH != SB_DATA_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        ULP_TOL >= (32'd1 << SB_MAG_W)) begin : g_bad_cfg
        $error("mx_sum_scoreboard: unsupported parameter set");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic data_match(input logic [SB_DATA_W-1:0] r,
                                        input logic [SB_DATA_W-1:0] d);
`ifdef MX_SUM_SB_ULP_TOL_EN
        logic match;
        if (is_nan(r) || is_nan(d)) begin
            match = is_nan(r) && is_nan(d);
        end else if (is_zero(r) && is_zero(d)) begin
            match = 1'b1;
        end else if (r[SB_DATA_W-1] != d[SB_DATA_W-1]) begin
            match = 1'b0;
        end else if (is_inf(r) || is_inf(d)) begin
            match = (r == d);
        end else begin
            match = (ulp_dist(r, d) <= SB_MAG_W'(ULP_TOL));
        end
        return match;
`else
        return r == d;
`endif
    endfunction

    sb_entry_t        ref_entry;
    sb_entry_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic             bypass;
    logic             orphan_now;
    logic             push;
    logic             pop;

    // Compare pipeline register
    logic                 stg_valid;
    logic                 stg_orphan;
    sb_entry_t            stg_ref;
    logic [SB_DATA_W-1:0] stg_dut_data;
    logic                 stg_dut_ovf;
    logic                 mismatch;

    logic [CNT_W-1:0]     txn_count;
    logic [CNT_W-1:0]     err_count;
    logic                 err_valid;
    logic [CNT_W-1:0]     err_id;
    logic [SB_DATA_W-1:0] err_ref;
    logic [SB_DATA_W-1:0] err_dut;
    logic                 orphan;

    always_comb begin
        ref_entry          = '0;
        ref_entry.data     = sb.i_ref_data;
        ref_entry.overflow = sb.i_ref_overflow;
        ref_entry.unused   = sb.i_ref_unused;
    end

    // Clear wins over any same-cycle handshake; bypass keeps an empty FIFO empty.
    assign bypass     = fifo_empty && sb.i_ref_valid && sb.i_dut_valid;
    assign orphan_now = fifo_empty && sb.i_dut_valid && !sb.i_ref_valid;
    assign push       = sb.i_ref_valid && !bypass && !sb.i_clear;
    assign pop        = sb.i_dut_valid && !sb.i_clear;

    mx_sum_sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (sb.i_clear),
        .push     (push),
        .pop      (pop),
        .wr_entry (ref_entry),
        .head_c   (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Every DUT result yields exactly one stage event: pop, bypass or orphan.
    always_ff @(posedge clk) begin
        if (!rst_n || sb.i_clear) begin
            stg_valid    <= 1'b0;
            stg_orphan   <= 1'b0;
            stg_ref      <= '0;
            stg_dut_data <= '0;
            stg_dut_ovf  <= 1'b0;
        end else begin
            stg_valid    <= sb.i_dut_valid;
            stg_orphan   <= orphan_now;
            stg_dut_data <= sb.i_dut_data;
            stg_dut_ovf  <= sb.i_dut_overflow;
            if (bypass) begin
                stg_ref <= ref_entry;
            end else if (fifo_empty) begin
                stg_ref <= '0;
            end else begin
                stg_ref <= head;
            end
        end
    end

    always_comb begin
        mismatch = 1'b0;
        if (!stg_ref.unused) begin
            mismatch = !data_match(stg_ref.data, stg_dut_data) ||
                       (stg_ref.overflow != stg_dut_ovf);
        end
    end

    // Counters and last-error capture; the id is the transaction count before increment.
    always_ff @(posedge clk) begin
        if (!rst_n || sb.i_clear) begin
            txn_count <= '0;
            err_count <= '0;
            err_valid <= 1'b0;
            err_id    <= '0;
            err_ref   <= '0;
            err_dut   <= '0;
            orphan    <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            if (stg_valid) begin
                if (stg_orphan) begin
                    orphan    <= 1'b1;
                    err_count <= sat_inc(err_count);
                    err_valid <= 1'b1;
                    err_id    <= txn_count;
                    err_ref   <= '0;
                    err_dut   <= stg_dut_data;
                end else begin
                    txn_count <= sat_inc(txn_count);
                    if (mismatch) begin
                        err_count <= sat_inc(err_count);
                        err_valid <= 1'b1;
                        err_id    <= txn_count;
                        err_ref   <= stg_ref.data;
                        err_dut   <= stg_dut_data;
                    end
                end
            end
        end
    end

    assign sb.o_ref_ready  = !fifo_full;
    assign sb.o_fifo_level = fifo_level;
    assign sb.o_txn_count  = txn_count;
    assign sb.o_err_count  = err_count;
    assign sb.o_err_valid  = err_valid;
    assign sb.o_err_id     = err_id;
    assign sb.o_err_ref    = err_ref;
    assign sb.o_err_dut    = err_dut;
    assign sb.o_orphan     = orphan;

endmodule
